// File: rtl/ppu_cmd_queue.sv
// Queue of processor PPU command words; words are visible one cycle after push (no bypass).
// A push is dropped only when the queue is full and no pop happens that cycle; the drop sets sticky overflow.
module ppu_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ppu_send,
  input  logic [31:0]      interface_data,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [31:0]      cmd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             pop;
  logic             push_ok;
  logic             push_drop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign cmd_valid = !empty;
  assign cmd_data  = mem[rd_ptr];

  assign pop       = cmd_valid && cmd_ready;
  // A pop frees the slot on the same edge, so a full queue can still take a push.
  assign push_ok   = ppu_send && (!full || pop);
  assign push_drop = ppu_send && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= interface_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CNT_W'(1);
      end
      // Set wins over clear so a drop coinciding with a clear is not lost.
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_cmd_queue.sv
// Scoreboard bench for ppu_cmd_queue: inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_ppu_cmd_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ppu_send = 1'b0;
  logic [31:0]   interface_data = '0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [31:0]   cmd_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int m_count = 0;
  bit m_ovf = 0;
  logic [31:0] sb [$];

  ppu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ppu_send(ppu_send), .interface_data(interface_data),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit send, input logic [31:0] data, input bit ready, input bit clr);
    ppu_send = send; interface_data = data; cmd_ready = ready; overflow_clr = clr;
  endtask

  // Advance one edge, updating the reference model from the inputs currently applied.
  task automatic tick();
    bit pop, push_ok;
    pop = (m_count != 0) && cmd_ready;
    push_ok = ppu_send && ((m_count < DEPTH) || pop);
    if (pop) void'(sb.pop_front());
    if (push_ok) sb.push_back(interface_data);
    m_count = m_count + int'(push_ok) - int'(pop);
    if (ppu_send && !push_ok) m_ovf = 1;
    else if (overflow_clr) m_ovf = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
      n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] w [3];
    w[0] = 32'hDEADBEEF; w[1] = 32'h00000001; w[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      drive(1, w[i], 0, 0); tick();
    end
    drive(0, '0, 0, 0);
    n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL fill_count: got %0d want 3", count); end
    n_cmp++; if (cmd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL fill_head: got %h want deadbeef", cmd_data); end
    drive(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== sb[0] || sb[0] !== w[i]) begin
        n_err++; $display("FAIL drain_word%0d: got v=%b %h want %h", i, cmd_valid, cmd_data, w[i]);
      end
      tick();
    end
    drive(0, '0, 0, 0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + i, 0, 0); tick();
    end
    drive(0, '0, 0, 0);
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", full); end
    n_cmp++; if (count !== CW'(8)) begin n_err++; $display("FAIL full_count: got %0d want 8", count); end
    drive(1, 32'h200, 0, 0); tick();
    drive(0, '0, 0, 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (count !== CW'(8)) begin n_err++; $display("FAIL ovf_count: got %0d want 8", count); end
    drive(0, '0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== sb[0] || cmd_data !== 32'h100 + i) begin
        n_err++; $display("FAIL ovf_drain%0d: got v=%b %h want %h", i, cmd_valid, cmd_data, 32'h100 + i);
      end
      tick();
    end
    drive(0, '0, 0, 0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drain_empty: got %b want 1 (dropped word leaked)", empty); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    drive(0, '0, 0, 1); tick();
    drive(0, '0, 0, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + i, 0, 0); tick();
    end
    drive(1, 32'h300, 1, 0);
    n_cmp++; if (cmd_data !== 32'h100) begin n_err++; $display("FAIL pp_head: got %h want 100", cmd_data); end
    tick();
    drive(0, '0, 0, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf: got %b want 0", overflow); end
    n_cmp++; if (count !== CW'(8)) begin n_err++; $display("FAIL pp_count: got %0d want 8", count); end
    n_cmp++; if (cmd_data !== 32'h101) begin n_err++; $display("FAIL pp_next: got %h want 101", cmd_data); end
    drive(0, '0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 32'h101 + i : 32'h300;
      n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== sb[0] || cmd_data !== exp) begin
        n_err++; $display("FAIL pp_drain%0d: got v=%b %h want %h", i, cmd_valid, cmd_data, exp);
      end
      tick();
    end
    drive(0, '0, 0, 0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL pp_empty: got %b want 1", empty); end
  endtask

  task automatic test_streaming();
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    bit send, rdy;
    while (popped < 40 && cyc < 600) begin
      send = (pushed < 40) && (m_count < DEPTH);
      rdy = 1'($urandom_range(0, 1));
      drive(send, 32'h1000 + pushed, rdy, 0);
      n_cmp++; if (cmd_valid !== (m_count != 0)) begin
        n_err++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, cmd_valid, m_count != 0);
      end
      if (rdy && m_count != 0) begin
        n_cmp++; if (cmd_data !== sb[0] || cmd_data !== 32'h1000 + popped) begin
          n_err++; $display("FAIL stream_data%0d: got %h want %h", popped, cmd_data, 32'h1000 + popped);
        end
        popped++;
      end
      if (send) pushed++;
      tick();
      n_cmp++; if (count !== CW'(m_count)) begin
        n_err++; $display("FAIL stream_count c%0d: got %0d want %0d", cyc, count, m_count);
      end
      cyc++;
    end
    drive(0, '0, 0, 0);
    n_cmp++; if (popped != 40) begin n_err++; $display("FAIL stream_timeout: got %0d words want 40", popped); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL stream_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h50 + i, 0, 0); tick();
    end
    drive(0, '0, 0, 0);
    n_cmp++; if (count !== CW'(5)) begin n_err++; $display("FAIL mid_pre_count: got %0d want 5", count); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL mid_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", empty); end
    sb.delete(); m_count = 0; m_ovf = 0;
    @(posedge clk); #1 rst = 1'b0;
    drive(1, 32'hA5A5A5A5, 0, 0); tick();
    drive(0, '0, 1, 0);
    n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL mid_first: got v=%b %h want a5a5a5a5", cmd_valid, cmd_data);
    end
    n_cmp++; if (count !== CW'(1)) begin n_err++; $display("FAIL mid_count_after: got %0d want 1", count); end
    tick();
    drive(0, '0, 0, 0);
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_final_empty: got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_overflow();
    test_push_pop_full();
    test_streaming();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
